// File: rtl/elbeth_pkg.sv
// Shared types and constants for the Elbeth pipeline control block.
package elbeth_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned MEM_RW_W = 4;
  localparam int unsigned PC_SEL_W = 2;
  localparam int unsigned WD_W     = 8;
  localparam int unsigned WD_LIMIT = 255;

  localparam logic [PC_SEL_W-1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [PC_SEL_W-1:0] PC_SEL_TRAP   = 2'b10;
  localparam logic [PC_SEL_W-1:0] PC_SEL_EPC    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_FETCH_WAIT = 2'd2,
    ST_TRAP       = 2'd3
  } state_t;

  // Pipeline steering bundle produced every cycle.
  typedef struct packed {
    logic                pc_stall;
    logic                if_id_stall;
    logic                id_exs_stall;
    logic                exs_wb_stall;
    logic                if_id_flush;
    logic                id_exs_flush;
    logic                exs_wb_flush;
    logic [PC_SEL_W-1:0] pc_sel;
    logic                bus_timeout;
  } ctrl_t;

  // A memory access with no write lanes enabled is a load.
  function automatic logic is_load(input logic mem_en, input logic [MEM_RW_W-1:0] mem_rw);
    return mem_en && (mem_rw == '0);
  endfunction

endpackage

// File: rtl/elbeth_hazard_detect.sv
// Combinational load-use comparison between the load in EXS and the ID sources.
module elbeth_hazard_detect
  import elbeth_pkg::*;
(
  input  logic [REG_AW-1:0]   id_rs1_addr,
  input  logic [REG_AW-1:0]   id_rs2_addr,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   exs_rd_addr,
  input  logic                exs_ctrl_mem_en,
  input  logic [MEM_RW_W-1:0] exs_ctrl_mem_rw,
  output logic                load_use_c
);

  logic exs_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so it cannot create a hazard.
  always_comb begin
    exs_load   = is_load(exs_ctrl_mem_en, exs_ctrl_mem_rw);
    rs1_hit    = id_rs1_used && (id_rs1_addr == exs_rd_addr);
    rs2_hit    = id_rs2_used && (id_rs2_addr == exs_rd_addr);
    load_use_c = exs_load && (exs_rd_addr != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/elbeth_pipeline_control.sv
// Pipeline hazard/stall/flush controller with data-memory watchdog.
module elbeth_pipeline_control
  import elbeth_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   id_rs1_addr,
  input  logic [REG_AW-1:0]   id_rs2_addr,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   exs_rd_addr,
  input  logic                exs_ctrl_mem_en,
  input  logic [MEM_RW_W-1:0] exs_ctrl_mem_rw,
  input  logic                exs_branch_taken,
  input  logic                exs_exception,
  input  logic                exs_eret,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                id_exs_stall,
  output logic                exs_wb_stall,
  output logic                if_id_flush,
  output logic                id_exs_flush,
  output logic                exs_wb_flush,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                bus_timeout
);

  // Count value whose increment reaches the limit in the current cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_d;
  logic              load_use_c;
  logic              trap_req;
  logic [PC_SEL_W-1:0] trap_sel;
  ctrl_t             ctrl;

  elbeth_hazard_detect u_hazard (
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .exs_rd_addr     (exs_rd_addr),
    .exs_ctrl_mem_en (exs_ctrl_mem_en),
    .exs_ctrl_mem_rw (exs_ctrl_mem_rw),
    .load_use_c      (load_use_c)
  );

  // State and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and zero-latency steering outputs.
  always_comb begin
    state_d       = state_q;
    ctrl          = '0;
    ctrl.pc_sel   = PC_SEL_PLUS4;
    wd_d          = '0;
    trap_req      = exs_exception || exs_eret;
    trap_sel      = exs_exception ? PC_SEL_TRAP : PC_SEL_EPC;

    case (state_q)
      ST_RUN: begin
        if (trap_req) begin
          ctrl.pc_sel       = trap_sel;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_exs_flush = 1'b1;
          ctrl.exs_wb_flush = 1'b1;
          state_d           = ST_TRAP;
        end else if (exs_ctrl_mem_en && !dmem_ready) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_exs_stall = 1'b1;
          ctrl.exs_wb_flush = 1'b1;
          state_d           = ST_MEM_WAIT;
        end else if (exs_branch_taken) begin
          ctrl.pc_sel       = PC_SEL_BRANCH;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_exs_flush = 1'b1;
        end else if (load_use_c) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_exs_flush = 1'b1;
        end else if (!imem_ready) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          state_d           = ST_FETCH_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (wd_q == WD_LAST) begin
          ctrl.bus_timeout  = 1'b1;
          ctrl.pc_sel       = PC_SEL_TRAP;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_exs_flush = 1'b1;
          ctrl.exs_wb_flush = 1'b1;
          state_d           = ST_TRAP;
        end else begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_exs_stall = 1'b1;
          ctrl.exs_wb_flush = 1'b1;
          wd_d              = wd_q + WD_W'(1);
        end
      end
      ST_FETCH_WAIT: begin
        if (trap_req) begin
          ctrl.pc_sel       = trap_sel;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_exs_flush = 1'b1;
          ctrl.exs_wb_flush = 1'b1;
          state_d           = ST_TRAP;
        end else if (imem_ready) begin
          state_d = ST_RUN;
        end else begin
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_flush = 1'b1;
        end
      end
      ST_TRAP: begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_flush = 1'b1;
        state_d          = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // A bubble always overrides a hold on the same register.
    ctrl.if_id_stall  = ctrl.if_id_stall  && !ctrl.if_id_flush;
    ctrl.id_exs_stall = ctrl.id_exs_stall && !ctrl.id_exs_flush;
    ctrl.exs_wb_stall = ctrl.exs_wb_stall && !ctrl.exs_wb_flush;

    // Reset drives bubbles into every register without waiting for a clock.
    if (!rst) begin
      state_d           = ST_RUN;
      wd_d              = '0;
      ctrl              = '0;
      ctrl.pc_sel       = PC_SEL_PLUS4;
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_exs_flush = 1'b1;
      ctrl.exs_wb_flush = 1'b1;
    end
  end

  // Unpack the steering bundle onto the ports.
  always_comb begin
    pc_stall     = ctrl.pc_stall;
    if_id_stall  = ctrl.if_id_stall;
    id_exs_stall = ctrl.id_exs_stall;
    exs_wb_stall = ctrl.exs_wb_stall;
    if_id_flush  = ctrl.if_id_flush;
    id_exs_flush = ctrl.id_exs_flush;
    exs_wb_flush = ctrl.exs_wb_flush;
    pc_sel       = ctrl.pc_sel;
    bus_timeout  = ctrl.bus_timeout;
  end

endmodule

// File: tb/tb_elbeth_pipeline_control.sv
// Directed bench for elbeth_pipeline_control.
module tb_elbeth_pipeline_control;
  import elbeth_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, exs_rd_addr;
  logic       id_rs1_used, id_rs2_used;
  logic       exs_ctrl_mem_en;
  logic [3:0] exs_ctrl_mem_rw;
  logic       exs_branch_taken, exs_exception, exs_eret;
  logic       imem_ready, dmem_ready;
  logic       pc_stall, if_id_stall, id_exs_stall, exs_wb_stall;
  logic       if_id_flush, id_exs_flush, exs_wb_flush;
  logic [1:0] pc_sel;
  logic       bus_timeout;

  // {pc_stall, if_id_stall, id_exs_stall, exs_wb_stall, if_id_flush, id_exs_flush, exs_wb_flush, pc_sel, bus_timeout}
  logic [9:0] obs;
  assign obs = {pc_stall, if_id_stall, id_exs_stall, exs_wb_stall,
                if_id_flush, id_exs_flush, exs_wb_flush, pc_sel, bus_timeout};

  localparam logic [9:0] V_DEF     = 10'b0000_000_00_0;
  localparam logic [9:0] V_RESET   = 10'b0000_111_00_0;
  localparam logic [9:0] V_LOADUSE = 10'b1100_010_00_0;
  localparam logic [9:0] V_MEMWAIT = 10'b1110_001_00_0;
  localparam logic [9:0] V_EXC     = 10'b0000_111_10_0;
  localparam logic [9:0] V_ERET    = 10'b0000_111_11_0;
  localparam logic [9:0] V_TIMEOUT = 10'b0000_111_10_1;
  localparam logic [9:0] V_BRANCH  = 10'b0000_110_01_0;
  localparam logic [9:0] V_FETCH   = 10'b1000_100_00_0;
  localparam logic [9:0] V_TRAP    = 10'b1000_100_00_0;

  int n_cmp  = 0;
  int n_fail = 0;

  elbeth_pipeline_control dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_addr      (id_rs1_addr),
    .id_rs2_addr      (id_rs2_addr),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .exs_rd_addr      (exs_rd_addr),
    .exs_ctrl_mem_en  (exs_ctrl_mem_en),
    .exs_ctrl_mem_rw  (exs_ctrl_mem_rw),
    .exs_branch_taken (exs_branch_taken),
    .exs_exception    (exs_exception),
    .exs_eret         (exs_eret),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .id_exs_stall     (id_exs_stall),
    .exs_wb_stall     (exs_wb_stall),
    .if_id_flush      (if_id_flush),
    .id_exs_flush     (id_exs_flush),
    .exs_wb_flush     (exs_wb_flush),
    .pc_sel           (pc_sel),
    .bus_timeout      (bus_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    id_rs1_addr      = 5'd0;
    id_rs2_addr      = 5'd0;
    id_rs1_used      = 1'b0;
    id_rs2_used      = 1'b0;
    exs_rd_addr      = 5'd0;
    exs_ctrl_mem_en  = 1'b0;
    exs_ctrl_mem_rw  = 4'd0;
    exs_branch_taken = 1'b0;
    exs_exception    = 1'b0;
    exs_eret         = 1'b0;
    imem_ready       = 1'b1;
    dmem_ready       = 1'b1;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [3:0] rw);
    exs_ctrl_mem_en = 1'b1;
    exs_ctrl_mem_rw = rw;
    exs_rd_addr     = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, V_RESET); end
    n_cmp++;
    if (dut.state_q !== ST_RUN || dut.wd_q !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: got state %0d wd %0d want 0/0", dut.state_q, dut.wd_q);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL post_reset_default: got %b want %b", obs, V_DEF); end
    next_cycle();
  endtask

  task automatic test_load_use();
    // rd=5 used by rs1: one bubble cycle
    set_load(5'd5, 4'd0); id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_LOADUSE) begin n_fail++; $display("FAIL load_use_rs1: got %b want %b", obs, V_LOADUSE); end
    next_cycle();
    idle_inputs(); id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL load_use_release: got %b want %b", obs, V_DEF); end
    next_cycle();
    // rd=0 never stalls
    idle_inputs(); set_load(5'd0, 4'd0); id_rs1_used = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL load_use_x0: got %b want %b", obs, V_DEF); end
    next_cycle();
    // rs2 match
    idle_inputs(); set_load(5'd7, 4'd0); id_rs2_addr = 5'd7; id_rs2_used = 1'b1; id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_LOADUSE) begin n_fail++; $display("FAIL load_use_rs2: got %b want %b", obs, V_LOADUSE); end
    next_cycle();
    // matching address but source not read
    idle_inputs(); set_load(5'd9, 4'd0); id_rs1_addr = 5'd9; id_rs2_addr = 5'd9;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL load_use_unused: got %b want %b", obs, V_DEF); end
    next_cycle();
    // store to a matching register is not a load
    idle_inputs(); set_load(5'd9, 4'b1111); id_rs1_addr = 5'd9; id_rs1_used = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL load_use_store: got %b want %b", obs, V_DEF); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_branch();
    exs_branch_taken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_BRANCH) begin n_fail++; $display("FAIL branch: got %b want %b", obs, V_BRANCH); end
    next_cycle();
    // branch suppresses a simultaneous load-use; branch also beats fetch wait
    set_load(5'd4, 4'd0); id_rs1_addr = 5'd4; id_rs1_used = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_BRANCH) begin n_fail++; $display("FAIL branch_over_loaduse: got %b want %b", obs, V_BRANCH); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF || dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL branch_stays_run: got %b state %0d want %b state 0", obs, dut.state_q, V_DEF);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    set_load(5'd2, 4'b0011);
    dmem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== V_MEMWAIT) begin n_fail++; $display("FAIL mem_wait_cyc%0d: got %b want %b", c, obs, V_MEMWAIT); end
      if (c == 3) begin
        n_cmp++;
        if (dut.wd_q !== 8'd1) begin n_fail++; $display("FAIL mem_wait_wd: got %0d want 1", dut.wd_q); end
      end
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL mem_wait_release: got %b want %b", obs, V_DEF); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (dut.state_q !== ST_RUN || dut.wd_q !== 8'd0 || obs !== V_DEF) begin
      n_fail++; $display("FAIL mem_wait_exit: got state %0d wd %0d out %b want 0/0/%b", dut.state_q, dut.wd_q, obs, V_DEF);
    end
    next_cycle();
  endtask

  task automatic test_timeout(input logic ready_at_limit);
    int bad;
    bad = 0;
    set_load(5'd6, 4'd0);
    dmem_ready = 1'b0;
    for (int c = 1; c <= 255; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== V_MEMWAIT) begin
        n_fail++;
        if (bad < 4) $display("FAIL timeout_wait_cyc%0d: got %b want %b", c, obs, V_MEMWAIT);
        bad++;
      end
      next_cycle();
    end
    dmem_ready = ready_at_limit;
    @(negedge clk);
    if (ready_at_limit) begin
      n_cmp++;
      if (obs !== V_DEF) begin n_fail++; $display("FAIL ready_at_limit: got %b want %b", obs, V_DEF); end
    end else begin
      n_cmp++;
      if (obs !== V_TIMEOUT) begin n_fail++; $display("FAIL timeout_pulse: got %b want %b", obs, V_TIMEOUT); end
    end
    next_cycle();
    idle_inputs();
    if (!ready_at_limit) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== V_TRAP || dut.state_q !== ST_TRAP) begin
        n_fail++; $display("FAIL timeout_trap: got %b state %0d want %b state 3", obs, dut.state_q, V_TRAP);
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF || dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL timeout_back_run: got %b state %0d want %b state 0", obs, dut.state_q, V_DEF);
    end
    next_cycle();
  endtask

  task automatic test_exc_branch();
    exs_exception = 1'b1; exs_branch_taken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_EXC) begin n_fail++; $display("FAIL exc_over_branch: got %b want %b", obs, V_EXC); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_TRAP || dut.state_q !== ST_TRAP) begin
      n_fail++; $display("FAIL exc_trap: got %b state %0d want %b state 3", obs, dut.state_q, V_TRAP);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF) begin n_fail++; $display("FAIL exc_back_run: got %b want %b", obs, V_DEF); end
    next_cycle();
  endtask

  task automatic test_fetch_eret();
    imem_ready = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== V_FETCH) begin n_fail++; $display("FAIL fetch_wait_cyc%0d: got %b want %b", c, obs, V_FETCH); end
      next_cycle();
    end
    exs_eret = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_ERET) begin n_fail++; $display("FAIL fetch_eret: got %b want %b", obs, V_ERET); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (obs !== V_TRAP) begin n_fail++; $display("FAIL eret_trap: got %b want %b", obs, V_TRAP); end
    next_cycle();
    // plain fetch wait ending on imem_ready
    imem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL fetch_enter: got %b want %b", obs, V_FETCH); end
    next_cycle();
    imem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF || dut.state_q !== ST_FETCH_WAIT) begin
      n_fail++; $display("FAIL fetch_release: got %b state %0d want %b state 2", obs, dut.state_q, V_DEF);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (dut.state_q !== ST_RUN) begin n_fail++; $display("FAIL fetch_back_run: got state %0d want 0", dut.state_q); end
    next_cycle();
  endtask

  task automatic test_reset_in_mem_wait();
    set_load(5'd8, 4'd0);
    dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_RESET || dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL async_reset: got %b state %0d want %b state 0", obs, dut.state_q, V_RESET);
    end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_DEF || dut.state_q !== ST_RUN || dut.wd_q !== 8'd0) begin
      n_fail++; $display("FAIL reset_release: got %b state %0d wd %0d want %b state 0 wd 0", obs, dut.state_q, dut.wd_q, V_DEF);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_exc_branch();
    test_fetch_eret();
    test_reset_in_mem_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
